// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A clock divider produces one
//   pixel tick every CLK_DIV cycles; on each tick the registered outputs load
//   the decode of the internal (h, v) counter pair and then h/v advance. The
//   outputs therefore lag the counters by one pixel but are always mutually
//   consistent with the reported X/Y.
//
// Ports
//   clk          in   pixel-domain clock
//   rst_n        in   asynchronous reset, active-low
//   en           in   run enable; low idles the block and restarts the raster
//   pix_tick     out  one-clk pulse per pixel period
//   hsync        out  horizontal sync, active level HS_POL
//   vsync        out  vertical sync, active level VS_POL
//   de           out  display enable, pixel inside the active area
//   x            out  current horizontal position, 0..H_TOTAL-1
//   y            out  current line, 0..V_TOTAL-1
//   line_start   out  high for the pixel period of x==0
//   frame_start  out  high for the pixel period of x==0, y==0
//   vblank       out  high while y >= V_ACTIVE
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned CLK_DIV  = 1,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);

    // Every porch/sync/active width must be non-zero, so all sync windows end
    // strictly before the last counter value and fit the XW/YW-bit compares.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_gen: timing parameters must all be non-zero");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    logic [DW-1:0] div_q;
    logic [XW-1:0] h_q;
    logic [YW-1:0] v_q;

    logic          tick;
    logic [DW-1:0] div_d;
    logic [XW-1:0] h_d;
    logic [YW-1:0] v_d;
    logic          de_d;
    logic          hs_act;
    logic          vs_act;
    logic          h_wrap;

    always_comb begin
        tick   = en && (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + 1'b1;

        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end

        de_d   = (h_q < H_ACT) && (v_q < V_ACT);
        hs_act = (h_q >= HS_BEG) && (h_q < HS_END);
        vs_act = (v_q >= VS_BEG) && (v_q < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            pix_tick    <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else if (!en) begin
            // Idle state is identical to reset so re-enabling starts at (0,0).
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            pix_tick    <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_tick <= tick;
            if (tick) begin
                hsync       <= hs_act ? HS_ON : ~HS_ON;
                vsync       <= vs_act ? VS_ON : ~VS_ON;
                de          <= de_d;
                x           <= h_q;
                y           <= v_q;
                line_start  <= (h_q == '0);
                frame_start <= (h_q == '0) && (v_q == '0);
                vblank      <= (v_q >= V_ACT);
                h_q         <= h_d;
                v_q         <= v_d;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Instance a: default horizontal timing
//   with a shortened vertical (8/2/2/3 lines) to keep the frame short. Instance
//   b: small mode, CLK_DIV=3, H 4/1/1/1, V 3/1/1/1, positive syncs.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, en_a;
    logic       pix_tick_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a, vblank_a;
    logic [9:0] x_a;
    logic [3:0] y_a;

    logic       rst_n_b, en_b;
    logic       pix_tick_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b, vblank_b;
    logic [2:0] x_b;
    logic [2:0] y_b;

    vga_timing_gen #(
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .en          (en_a),
        .pix_tick    (pix_tick_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .de          (de_a),
        .x           (x_a),
        .y           (y_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a),
        .vblank      (vblank_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (1),
        .H_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (1),
        .VS_POL   (1),
        .CLK_DIV  (3)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .en          (en_b),
        .pix_tick    (pix_tick_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .de          (de_b),
        .x           (x_b),
        .y           (y_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b),
        .vblank      (vblank_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int edges, t, last_c, fs_c, ls2_c, ex, ey, k;
        int e_per, e_xy, e_hs, e_vs, e_ls, e_hold, e_de;
        int hs_low, vs_low, ls_cnt, fs2_n, hs_first, hs_last;
        logic [2:0] prev_x;

        rst_n_a = 1'b0; en_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b0;
        repeat (2) step();

        // Reset values
        check("a_rst_x",      32'(x_a), 0);
        check("a_rst_y",      32'(y_a), 0);
        check("a_rst_de",     32'(de_a), 0);
        check("a_rst_hsync",  32'(hsync_a), 1);
        check("a_rst_vsync",  32'(vsync_a), 1);
        check("a_rst_tick",   32'(pix_tick_a), 0);
        check("a_rst_ls",     32'(line_start_a), 0);
        check("a_rst_fs",     32'(frame_start_a), 0);
        check("a_rst_vblank", 32'(vblank_a), 0);
        check("b_rst_hsync",  32'(hsync_b), 0);
        check("b_rst_vsync",  32'(vsync_b), 0);

        // ---------------- small mode, CLK_DIV=3 ----------------
        rst_n_b = 1'b1; en_b = 1'b1;
        edges = 0;
        do begin
            step();
            edges++;
        end while (!pix_tick_b && edges < 10);
        check("b_first_tick_lat", 32'(edges), 3);
        check("b_first_x",  32'(x_b), 0);
        check("b_first_y",  32'(y_b), 0);
        check("b_first_fs", 32'(frame_start_b), 1);
        check("b_first_de", 32'(de_b), 1);

        t = 0; last_c = 0; fs_c = -1; ls2_c = -1; prev_x = x_b;
        e_per = 0; e_xy = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_hold = 0; e_de = 0;
        for (int c = 1; c <= 129; c++) begin
            step();
            if (pix_tick_b) begin
                if (c - last_c != 3) e_per++;
                last_c = c;
                t++;
                ex = t % 7;
                ey = (t / 7) % 6;
                if (32'(x_b) != ex || 32'(y_b) != ey) e_xy++;
                if (hsync_b !== (ex == 5)) e_hs++;
                if (vsync_b !== (ey == 4)) e_vs++;
                if (de_b !== (ex < 4 && ey < 3)) e_de++;
                if (line_start_b !== (ex == 0)) e_ls++;
                if (frame_start_b && fs_c < 0) fs_c = c;
                if (line_start_b && ls2_c < 0) ls2_c = c;
                prev_x = x_b;
            end else begin
                if (x_b !== prev_x) e_hold++;
            end
        end
        check("b_tick_period",   32'(e_per), 0);
        check("b_xy_seq",        32'(e_xy), 0);
        check("b_hsync_x5",      32'(e_hs), 0);
        check("b_vsync_y4",      32'(e_vs), 0);
        check("b_de",            32'(e_de), 0);
        check("b_line_start",    32'(e_ls), 0);
        check("b_hold",          32'(e_hold), 0);
        check("b_line_period",   32'(ls2_c), 21);
        check("b_frame_period",  32'(fs_c), 126);
        en_b = 1'b0;

        // ---------------- default horizontal, CLK_DIV=1 ----------------
        rst_n_a = 1'b1; en_a = 1'b1;
        step();
        check("a_first_x",     32'(x_a), 0);
        check("a_first_y",     32'(y_a), 0);
        check("a_first_de",    32'(de_a), 1);
        check("a_first_ls",    32'(line_start_a), 1);
        check("a_first_fs",    32'(frame_start_a), 1);
        check("a_first_tick",  32'(pix_tick_a), 1);
        check("a_first_hsync", 32'(hsync_a), 1);

        e_xy = 0; e_hs = 0; e_vs = 0; e_de = 0; e_ls = 0; e_per = 0;
        hs_low = 0; vs_low = 0; ls_cnt = 1; fs2_n = -1; hs_first = -1; hs_last = -1;
        for (int n = 1; n <= 12005; n++) begin
            step();
            ex = n % 800;
            ey = (n / 800) % 15;
            if (32'(x_a) != ex || 32'(y_a) != ey) e_xy++;
            if (hsync_a !== !(ex >= 656 && ex < 752)) e_hs++;
            if (vsync_a !== !(ey == 10 || ey == 11)) e_vs++;
            if (de_a !== (ex < 640 && ey < 8)) e_de++;
            if (vblank_a !== (ey >= 8)) e_per++;
            if (line_start_a !== (ex == 0)) e_ls++;
            if (n < 12000) begin
                if (!hsync_a) hs_low++;
                if (!vsync_a) vs_low++;
                if (line_start_a) ls_cnt++;
            end
            if (n < 800 && !hsync_a) begin
                if (hs_first < 0) hs_first = 32'(x_a);
                hs_last = 32'(x_a);
            end
            if (frame_start_a && fs2_n < 0) fs2_n = n;
            if (n == 11999) begin
                check("a_corner_x",      32'(x_a), 799);
                check("a_corner_y",      32'(y_a), 14);
                check("a_corner_vblank", 32'(vblank_a), 1);
            end
            if (n == 12000) begin
                check("a_wrap_x",      32'(x_a), 0);
                check("a_wrap_y",      32'(y_a), 0);
                check("a_wrap_fs",     32'(frame_start_a), 1);
                check("a_wrap_vblank", 32'(vblank_a), 0);
            end
        end
        check("a_xy_seq",       32'(e_xy), 0);
        check("a_hsync_window", 32'(e_hs), 0);
        check("a_vsync_window", 32'(e_vs), 0);
        check("a_de",           32'(e_de), 0);
        check("a_vblank",       32'(e_per), 0);
        check("a_line_start",   32'(e_ls), 0);
        check("a_hs_low_count", 32'(hs_low), 15 * 96);
        check("a_vs_low_count", 32'(vs_low), 1600);
        check("a_ls_count",     32'(ls_cnt), 15);
        check("a_hs_first_x",   32'(hs_first), 656);
        check("a_hs_last_x",    32'(hs_last), 751);
        check("a_frame_period", 32'(fs2_n), 12000);

        // EN drop mid-frame at (300, 5)
        k = 0;
        while (!(x_a == 10'd300 && y_a == 4'd5) && k < 20000) begin
            step();
            k++;
        end
        check("a_reach_x300", 32'(x_a), 300);
        check("a_reach_de",   32'(de_a), 1);
        en_a = 1'b0;
        step();
        check("a_endrop_x",     32'(x_a), 0);
        check("a_endrop_y",     32'(y_a), 0);
        check("a_endrop_de",    32'(de_a), 0);
        check("a_endrop_hsync", 32'(hsync_a), 1);
        check("a_endrop_vsync", 32'(vsync_a), 1);
        check("a_endrop_tick",  32'(pix_tick_a), 0);
        repeat (3) step();
        check("a_idle_x",       32'(x_a), 0);
        check("a_idle_de",      32'(de_a), 0);
        en_a = 1'b1;
        step();
        check("a_reen_x",  32'(x_a), 0);
        check("a_reen_y",  32'(y_a), 0);
        check("a_reen_fs", 32'(frame_start_a), 1);
        check("a_reen_de", 32'(de_a), 1);
        step();
        check("a_reen_x1", 32'(x_a), 1);

        // Async reset mid-HSYNC
        k = 0;
        while (x_a != 10'd700 && k < 2000) begin
            step();
            k++;
        end
        check("a_mid_hs_x",     32'(x_a), 700);
        check("a_mid_hs_hsync", 32'(hsync_a), 0);
        @(negedge clk);
        #2;
        rst_n_a = 1'b0;
        #1;
        check("a_arst_x",     32'(x_a), 0);
        check("a_arst_hsync", 32'(hsync_a), 1);
        check("a_arst_de",    32'(de_a), 0);
        #1;
        rst_n_a = 1'b1;
        step();
        check("a_post_rst_x",  32'(x_a), 0);
        check("a_post_rst_y",  32'(y_a), 0);
        check("a_post_rst_fs", 32'(frame_start_a), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
